// File: rtl/agc_level_ctrl_if.sv
// Control/status bundle between the AGC level controller and its environment.
// The master drives the run request and comparator inputs; the slave is the controller.
interface agc_level_ctrl_if;
  logic start;
  logic cmp_hi;
  logic cmp_lo;
  logic search_done;
  logic adjust;
  logic up_dn;
  logic busy;
  logic agc_done;
  logic locked;

  modport master (
    output start, cmp_hi, cmp_lo, search_done,
    input  adjust, up_dn, busy, agc_done, locked
  );

  modport slave (
    input  start, cmp_hi, cmp_lo, search_done,
    output adjust, up_dn, busy, agc_done, locked
  );
endinterface

// File: rtl/agc_level_ctrl.sv
// AGC level controller: settles, counts comparator hits over a window, then steps the
// downstream gain search up or down until the level is in range or the search is exhausted.
module agc_level_ctrl #(
  parameter int WIN_LEN    = 64,
  parameter int SETTLE_LEN = 16,
  parameter int HI_THRESH  = 4,
  parameter int LO_THRESH  = 8,
  parameter int MAX_STEPS  = 8
) (
  input  logic             clk,
  input  logic             RESET,
  agc_level_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_DECIDE  = 3'd3,
    S_ADJUST  = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_LEN - 1);
  localparam logic [7:0] WIN_LAST    = 8'(WIN_LEN - 1);
  localparam logic [7:0] HI_TH       = 8'(HI_THRESH);
  localparam logic [7:0] LO_TH       = 8'(LO_THRESH);
  localparam logic [3:0] STEP_MAX    = 4'(MAX_STEPS);

  state_e     state_q;
  logic [7:0] timer_q;
  logic [7:0] hi_cnt_q;
  logic [7:0] lo_cnt_q;
  logic [3:0] step_cnt_q;
  logic       lock_q;
  logic       adjust_q;
  logic       up_dn_q;
  logic       busy_q;
  logic       agc_done_q;
  logic       locked_q;

  // Outputs are decoded from the current state one edge later, which keeps every
  // output a plain flop and gives the SETTLE+WIN+2 cycle step period.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      timer_q    <= 8'd0;
      hi_cnt_q   <= 8'd0;
      lo_cnt_q   <= 8'd0;
      step_cnt_q <= 4'd0;
      lock_q     <= 1'b0;
      adjust_q   <= 1'b0;
      up_dn_q    <= 1'b0;
      busy_q     <= 1'b0;
      agc_done_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      adjust_q   <= (state_q == S_ADJUST);
      agc_done_q <= (state_q == S_DONE);
      busy_q     <= (state_q != S_IDLE) && (state_q != S_DONE);
      locked_q   <= (state_q == S_DONE) && lock_q;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q    <= S_SETTLE;
            timer_q    <= 8'd0;
            step_cnt_q <= 4'd0;
            lock_q     <= 1'b0;
            hi_cnt_q   <= 8'd0;
            lo_cnt_q   <= 8'd0;
          end else begin
            state_q <= state_q;
          end
        end
        S_SETTLE: begin
          if (timer_q == SETTLE_LAST) begin
            state_q  <= S_MEASURE;
            timer_q  <= 8'd0;
            hi_cnt_q <= 8'd0;
            lo_cnt_q <= 8'd0;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        S_MEASURE: begin
          if (bus.cmp_hi && (hi_cnt_q != 8'hFF)) begin
            hi_cnt_q <= hi_cnt_q + 8'd1;
          end else begin
            hi_cnt_q <= hi_cnt_q;
          end
          if (bus.cmp_lo && (lo_cnt_q != 8'hFF)) begin
            lo_cnt_q <= lo_cnt_q + 8'd1;
          end else begin
            lo_cnt_q <= lo_cnt_q;
          end
          if (timer_q == WIN_LAST) begin
            state_q <= S_DECIDE;
            timer_q <= 8'd0;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        S_DECIDE: begin
          // Too loud wins over too quiet; a step is only taken while the search can still move.
          if ((hi_cnt_q > HI_TH) || (lo_cnt_q < LO_TH)) begin
            up_dn_q <= !(hi_cnt_q > HI_TH);
            lock_q  <= 1'b0;
            if (bus.search_done || (step_cnt_q == STEP_MAX)) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_ADJUST;
            end
          end else begin
            lock_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_ADJUST: begin
          step_cnt_q <= step_cnt_q + 4'd1;
          timer_q    <= 8'd0;
          state_q    <= S_SETTLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.adjust   = adjust_q;
  assign bus.up_dn    = up_dn_q;
  assign bus.busy     = busy_q;
  assign bus.agc_done = agc_done_q;
  assign bus.locked   = locked_q;

endmodule

// File: tb/tb_agc_level_ctrl.sv
// Scoreboard bench for agc_level_ctrl: stimulus queues expected adjust/done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_agc_level_ctrl;
  localparam int STEP = 82;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  agc_level_ctrl_if bus_if ();
  agc_level_ctrl dut (.clk(clk), .RESET(rst), .bus(bus_if));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int at; logic val; } ev_t;  // kind 1 = adjust, 2 = done
  ev_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic done_prev = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic note_event(int kind, logic val);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_cycle", cyc, e.at);
      check("ev_value", {31'd0, val}, {31'd0, e.val});
    end
  endtask

  // Monitor: one event per adjust cycle and per rising edge of agc_done.
  always @(negedge clk) begin
    if (bus_if.adjust === 1'b1) note_event(1, bus_if.up_dn);
    if ((bus_if.agc_done === 1'b1) && !done_prev) note_event(2, bus_if.locked);
    done_prev <= (bus_if.agc_done === 1'b1);
  end

  task automatic push(int kind, int at, logic val);
    ev_t e;
    e.kind = kind;
    e.at = at;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic start_pulse(output int k);
    @(negedge clk);
    k = cyc + 1;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic wait_drain(int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_done(logic lv);
    repeat (3) @(negedge clk);
    check("done_flag", {31'd0, bus_if.agc_done}, 32'd1);
    check("done_busy", {31'd0, bus_if.busy}, 32'd0);
    check("done_locked", {31'd0, bus_if.locked}, {31'd0, lv});
  endtask

  task automatic check_zero(string name);
    check(name, {27'd0, bus_if.adjust, bus_if.up_dn, bus_if.busy, bus_if.agc_done, bus_if.locked},
          32'd0);
  endtask

  // One run where the first window carries nh hi hits (at its end) and nl lo hits (at its start);
  // everything else reads as in range so any step is followed by a locked finish.
  task automatic run_bound(int nh, int nl, int step_kind, logic dir);
    int k;
    int idx;
    bus_if.cmp_hi = 1'b0;
    bus_if.cmp_lo = 1'b1;
    start_pulse(k);
    if (step_kind == 1) begin
      push(1, k + STEP, dir);
      push(2, k + 2 * STEP, 1'b1);
    end else begin
      push(2, k + STEP, 1'b1);
    end
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
      idx = cyc - (k + 16);
      if (idx >= 0 && idx < 64) begin
        bus_if.cmp_hi = (idx >= 64 - nh);
        bus_if.cmp_lo = (idx < nl);
      end else begin
        bus_if.cmp_hi = 1'b0;
        bus_if.cmp_lo = 1'b1;
      end
      @(negedge clk);
    end
    wait_drain(1);
    check_done(1'b1);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus_if.start = 1'b1;
    bus_if.cmp_hi = 1'b0;
    bus_if.cmp_lo = 1'b0;
    bus_if.search_done = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_outs");
    rst = 1'b0;
    bus_if.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check_zero("idle_outs");
    end

    // In range on the first window.
    bus_if.cmp_lo = 1'b1;
    start_pulse(k);
    push(2, k + STEP, 1'b1);
    wait_drain(300);
    check_done(1'b1);

    // Too loud until the step budget runs out.
    bus_if.cmp_hi = 1'b1;
    bus_if.cmp_lo = 1'b0;
    start_pulse(k);
    for (int i = 0; i < 8; i++) push(1, k + STEP * (i + 1), 1'b0);
    push(2, k + STEP * 9, 1'b0);
    wait_drain(1000);
    check_done(1'b0);

    // Too quiet, search exhausts after the third step.
    bus_if.cmp_hi = 1'b0;
    bus_if.cmp_lo = 1'b0;
    start_pulse(k);
    for (int i = 0; i < 3; i++) push(1, k + STEP * (i + 1), 1'b1);
    push(2, k + STEP * 4, 1'b0);
    while (cyc < k + 3 * STEP) @(negedge clk);
    bus_if.search_done = 1'b1;
    wait_drain(200);
    check_done(1'b0);
    bus_if.search_done = 1'b0;

    run_bound(4, 8, 0, 1'b0);
    run_bound(5, 8, 1, 1'b0);
    run_bound(0, 7, 1, 1'b1);
    run_bound(64, 64, 1, 1'b0);

    // A start pulse inside MEASURE must not disturb the run.
    bus_if.cmp_hi = 1'b0;
    bus_if.cmp_lo = 1'b1;
    start_pulse(k);
    push(2, k + STEP, 1'b1);
    while (cyc < k + 40) @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_drain(200);
    check_done(1'b1);

    // Reset in the middle of a loud run: no pulse may follow.
    bus_if.cmp_hi = 1'b1;
    bus_if.cmp_lo = 1'b0;
    start_pulse(k);
    while (cyc < k + 50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("abort_outs");
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check_zero("abort_idle");
    end

    // Fresh run after the abort.
    start_pulse(k);
    for (int i = 0; i < 8; i++) push(1, k + STEP * (i + 1), 1'b0);
    push(2, k + STEP * 9, 1'b0);
    wait_drain(1000);
    check_done(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/agc_level_ctrl.md
AGC_LEVEL_CTRL -- requirements
Module: agc_level_ctrl

Interface
REQ-001 Parameter WIN_LEN, default 64, meaning measurement window length in cycles; legal range 1..255.
REQ-002 Parameter SETTLE_LEN, default 16, meaning wait cycles after start or after each gain step; legal range 1..255.
REQ-003 Parameter HI_THRESH, default 4, meaning maximum cmp_hi count per window still judged not too large.
REQ-004 Parameter LO_THRESH, default 8, meaning minimum cmp_lo count per window judged large enough.
REQ-005 Parameter MAX_STEPS, default 8, meaning maximum adjust pulses per run; legal range 1..15.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high.
REQ-007 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-008 Port RESET, input, 1 bit: synchronous active-high reset.
REQ-009 Port start, input, 1 bit: begins a run; it is sampled only in IDLE or DONE.
REQ-010 Port cmp_hi, input, 1 bit: signal-above-upper-threshold comparator, already synchronous to clk.
REQ-011 Port cmp_lo, input, 1 bit: signal-above-lower-threshold comparator, already synchronous to clk.
REQ-012 Port search_done, input, 1 bit: gain search exhausted, from the downstream gain binary search stage.
REQ-013 Port adjust, output, 1 bit: one-cycle gain step request to the downstream gain binary search stage.
REQ-014 Port up_dn, output, 1 bit: step direction, where 1 means increase gain; it is valid whenever adjust=1.
REQ-015 Port busy, output, 1 bit: high in every state other than IDLE and DONE.
REQ-016 Port agc_done, output, 1 bit: high while in DONE.
REQ-017 Port locked, output, 1 bit: high in DONE only when the last window was judged in range.

Function
REQ-018 The block SHALL implement a state machine with states IDLE, SETTLE, MEASURE, DECIDE, ADJUST and DONE.
REQ-019 IDLE or DONE with start=1: the block SHALL go to SETTLE, clear step_cnt and locked, and clear the settle and window counters.
REQ-020 In busy states, start SHALL be ignored.
REQ-021 SETTLE SHALL last exactly SETTLE_LEN cycles, then go to MEASURE with hi_cnt and lo_cnt cleared.
REQ-022 MEASURE SHALL last exactly WIN_LEN cycles, then go to DECIDE.
  - Each cycle, hi_cnt increments if cmp_hi=1 and lo_cnt increments if cmp_lo=1.
  - Both counters may increment in the same cycle.
  - Both counters are 8 bits and saturate at 255.
  - cmp_hi and cmp_lo are ignored outside MEASURE.
REQ-023 DECIDE SHALL last one cycle and evaluate the following rules in priority order:
  - (a) hi_cnt > HI_THRESH: direction down (up_dn<=0).
  - (b) else lo_cnt < LO_THRESH: direction up (up_dn<=1).
  - (c) else: go to DONE with locked<=1.
  - For (a) or (b): if search_done=1 or step_cnt==MAX_STEPS, go to DONE with locked<=0; otherwise go to ADJUST.
REQ-024 ADJUST SHALL last one cycle with adjust=1, increment step_cnt (4 bits), then go to SETTLE.
REQ-025 All outputs SHALL be registered.
  - adjust=1 only in ADJUST.
  - up_dn holds its last decided value between steps.
REQ-026 Latency: with start sampled at edge k, the first adjust or agc_done assertion SHALL occur in the cycle following edge k+SETTLE_LEN+WIN_LEN+2 (edge k+82 with defaults).
REQ-027 Step period: consecutive adjust pulses SHALL be SETTLE_LEN+WIN_LEN+2 cycles apart (82 with defaults).
REQ-028 DONE SHALL hold agc_done=1, busy=0 and locked stable until RESET or start.
REQ-029 The block SHALL NOT reinitialise the downstream gain array; on restart, the downstream gain stage is reset externally.

Reset
REQ-030 RESET=1 at a rising edge SHALL force IDLE and clear step_cnt, hi_cnt, lo_cnt and all timers.
  - Output reset values: adjust=0, up_dn=0, busy=0, agc_done=0, locked=0.
REQ-031 RESET mid-run SHALL abort the run with no further adjust pulse.
REQ-032 RESET SHALL take priority over start in the same cycle.

Verification
REQ-033 Reset then idle:
  - Stimulus: RESET=1 for 2 cycles, then start=0 for 200 cycles.
  - Response: all outputs 0 throughout.
REQ-034 In range on first pass:
  - Stimulus: cmp_hi=0, cmp_lo=1, start pulse at edge k.
  - Response: agc_done=1 and locked=1 from edge k+82; adjust never asserted.
REQ-035 Too loud and exhausted:
  - Stimulus: cmp_hi=1, search_done=0.
  - Response: exactly 8 adjust pulses with up_dn=0, 82 cycles apart; then agc_done=1, locked=0.
REQ-036 Early stop on search_done:
  - Stimulus: cmp_lo=0, cmp_hi=0; search_done raised after the 3rd pulse.
  - Response: exactly 3 pulses, all with up_dn=1; then agc_done=1, locked=0.
REQ-037 Threshold boundaries, per window:
  - hi_cnt=4 and lo_cnt=8: locked.
  - hi_cnt=5: step down.
  - hi_cnt=0 and lo_cnt=7: step up.
  - cmp_hi and cmp_lo both 1 on all 64 cycles: step down.
REQ-038 Abort and ignore:
  - Stimulus: start pulse during MEASURE.
  - Response: the pulse is ignored and timing is unchanged.
  - Stimulus: RESET=1 mid-MEASURE.
  - Response: IDLE, all outputs 0, no adjust pulse.
  - Stimulus: start after reset.
  - Response: full fresh run.
